// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply (radix-2 shift-add) and divide (restoring) controller.
// One iteration per clock; a new start pulse aborts any running operation.
module multdiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t             state, state_next;
   logic [5:0]         cnt, cnt_next;
   logic [WIDTH-1:0]   mag, mag_next;
   logic [2*WIDTH-1:0] work, work_next;
   logic               neg, neg_next;
   logic [WIDTH-1:0]   result_next;
   logic               exc_next;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] mul_step, div_step;
   logic [2*WIDTH-1:0] prod_signed;
   logic [WIDTH-1:0]   quo_signed;
   logic               prod_ovf, quo_ovf;
   logic               last_iter;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + 1'b1) : x;
   endfunction

   // mag holds the multiplicand (MUL) or divisor (DIV) magnitude; work holds
   // {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   always_comb begin
      sum      = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? mag : '0)};
      mul_step = {sum, work[WIDTH-1:1]};
      diff     = work[2*WIDTH-1:WIDTH-1] - {1'b0, mag};
      div_step = diff[WIDTH] ? {work[2*WIDTH-2:0], 1'b0}
                             : {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      prod_signed = neg ? (~work + 1'b1) : work;
      prod_ovf    = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
      quo_signed  = neg ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
      // A positive quotient of magnitude 2^31 only arises from MIN / -1.
      quo_ovf     = ~neg & work[WIDTH-1];
      last_iter   = (cnt == 6'(WIDTH));
   end

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      mag_next    = mag;
      work_next   = work;
      neg_next    = neg;
      result_next = data_result;
      exc_next    = data_exception;

      case (state)
         MUL: begin
            if (last_iter) begin
               result_next = prod_signed[WIDTH-1:0];
               exc_next    = prod_ovf;
               state_next  = DONE;
            end else begin
               work_next = mul_step;
               cnt_next  = cnt + 6'd1;
            end
         end
         DIV: begin
            if (mag == '0) begin
               result_next = '0;
               exc_next    = 1'b1;
               state_next  = DONE;
            end else if (last_iter) begin
               result_next = quo_signed;
               exc_next    = quo_ovf;
               state_next  = DONE;
            end else begin
               work_next = div_step;
               cnt_next  = cnt + 6'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // A start pulse wins over whatever the current state would do.
      if (ctrl_MULT || ctrl_DIV) begin
         cnt_next = '0;
         neg_next = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         if (ctrl_MULT && ctrl_DIV) begin
            result_next = '0;
            exc_next    = 1'b1;
            state_next  = DONE;
         end else if (ctrl_MULT) begin
            mag_next   = abs_val(data_operandA);
            work_next  = {{WIDTH{1'b0}}, abs_val(data_operandB)};
            state_next = MUL;
         end else begin
            mag_next   = abs_val(data_operandB);
            work_next  = {{WIDTH{1'b0}}, abs_val(data_operandA)};
            state_next = DIV;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= '0;
         mag            <= '0;
         work           <= '0;
         neg            <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         mag            <= mag_next;
         work           <= work_next;
         neg            <= neg_next;
         data_result    <= result_next;
         data_exception <= exc_next;
      end
   end

   // A zero divisor never iterates, so it is not reported as busy.
   assign busy           = (state == MUL) || ((state == DIV) && (mag != '0));
   assign data_resultRDY = (state == DONE);

endmodule
